fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage ahead of the combinational instruction_mem.
//  - Owns the program counter and drives it to instruction_mem.pc.
//  - Latches instruction_mem.instr_out, together with its PC, into the IF/ID pipeline register.
//  - Handles stall, branch/jump redirect with wrong-path squash, and a HALT instruction.
// PARAMETERS
//  PC_WIDTH     16       program counter width (word address, +1 per instruction)
//  INSTR_WIDTH  16       instruction width
//  RESET_PC     16'h0000 PC value loaded on reset
//  NOP_INSTR    16'h0000 encoding inserted into IF/ID on squash/reset
//  HALT_INSTR   16'hFFFF encoding that halts fetch
// PORTS
//  clk              in   1            rising-edge clock
//  rst              in   1            asynchronous, active-high reset
//  stall_i          in   1            hold PC and IF/ID (hazard from decode)
//  branch_taken_i   in   1            redirect to branch_target_i
//  branch_target_i  in   PC_WIDTH     branch destination
//  jump_i           in   1            redirect to jump_target_i
//  jump_target_i    in   PC_WIDTH     jump destination
//  instr_in         in   INSTR_WIDTH  from instruction_mem.instr_out (valid same cycle as pc_out)
//  pc_out           out  PC_WIDTH     registered PC, to instruction_mem.pc
//  if_id_instr      out  INSTR_WIDTH  IF/ID instruction
//  if_id_pc         out  PC_WIDTH     IF/ID PC of if_id_instr
//  if_id_valid      out  1            IF/ID holds a real instruction
//  halted_o         out  1            fetch is halted
// BEHAVIOUR
//  Reset (async, any time):
//  - pc_out=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0, halted_o=0.
//  - State is BOOT.
//  States: BOOT, RUN, HALT. All updates occur on the rising edge of clk.
//  BOOT: lasts exactly one cycle after rst deasserts.
//  - Next state is RUN; pc holds; if_id_valid stays 0.
//  - If a redirect is present: pc<=target and next state is RUN.
//  RUN: actions in priority order (highest first).
//   1 branch_taken_i: pc<=branch_target_i; IF/ID<={NOP_INSTR,0,valid 0}.
//   2 jump_i: pc<=jump_target_i; IF/ID squashed as above.
//   3 stall_i: pc, IF/ID, and state all hold.
//   4 instr_in==HALT_INSTR:
//     - IF/ID<={instr_in,pc_out,valid 1}; pc holds.
//     - Next state HALT; halted_o<=1.
//   5 otherwise: IF/ID<={instr_in,pc_out,valid 1}; pc<=pc+1.
//  HALT:
//  - pc holds; if_id_valid<=0 on the first HALT edge and stays 0; stall_i is ignored.
//  - branch_taken_i (priority) or jump_i: pc<=target, IF/ID squashed, next state RUN, halted_o<=0.
//  Other rules:
//  - Branch and jump asserted together: branch wins.
//  - A redirect wins over stall_i in every state.
//  - Latency: instruction at PC p appears in IF/ID 1 edge after pc_out==p (no stall).
//  - PC arithmetic is modulo 2^PC_WIDTH: 16'hFFFF+1 -> 16'h0000, with no flag.
//  - Reset mid-operation aborts everything; fetch resumes at RESET_PC after one BOOT cycle.
// TESTING
//  T1 rst 1->0, mem[n]=16'h1000+n:
//     - edge1 (BOOT): pc 0, valid 0.
//     - then IF/ID shows (16'h1000,0), (16'h1001,1), ... with valid 1; pc 1,2,...
//  T2 stall_i high 3 cycles at pc=5:
//     - pc stays 5; IF/ID holds (mem[4],4,valid 1).
//     - after release, (mem[5],5) is captured.
//  T3 stall_i, branch_taken_i (target 16'd30) and jump_i (target 16'd57) all high at pc=8:
//     - next pc=30; IF/ID={NOP,0,valid 0}.
//     - next edge captures (mem[30],30,valid 1).
//  T4 mem[12]=16'hFFFF reached:
//     - IF/ID=(16'hFFFF,12,valid 1), halted_o=1, pc stuck at 12.
//     - valid 0 on the following edge.
//     - jump_i to 16'd158 resumes: halted_o=0, pc=158.
//  T5 jump to 16'hFFFF:
//     - edge after jump: pc=16'hFFFF.
//     - next edge: IF/ID pc 16'hFFFF, pc=16'h0000.
//  T6 rst asserted between edges mid-run:
//     - outputs go to reset values immediately, with no clock edge.
//     - after deassert, T1 sequence repeats.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, feeds instruction_mem, and fills the IF/ID
// register while handling stall, branch/jump redirect with squash, and HALT.
module fetch_unit #(
  parameter int unsigned               PC_WIDTH    = 16,
  parameter int unsigned               INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]       RESET_PC    = 16'h0000,
  parameter logic [INSTR_WIDTH-1:0]    NOP_INSTR   = 16'h0000,
  parameter logic [INSTR_WIDTH-1:0]    HALT_INSTR  = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_taken_i,
  input  logic [PC_WIDTH-1:0]    branch_target_i,
  input  logic                   jump_i,
  input  logic [PC_WIDTH-1:0]    jump_target_i,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic                   if_id_valid,
  output logic                   halted_o
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    ifpc_q, ifpc_d;
  logic                   valid_q, valid_d;

  logic                   redirect;
  logic [PC_WIDTH-1:0]    redirectTarget;

  // Branch outranks jump when both are asserted.
  assign redirect       = branch_taken_i | jump_i;
  assign redirectTarget = branch_taken_i ? branch_target_i : jump_target_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        if (redirect) pc_d = redirectTarget;
      end
      RUN: begin
        if (redirect) begin
          pc_d    = redirectTarget;
          instr_d = NOP_INSTR;
          ifpc_d  = '0;
          valid_d = 1'b0;
        end else if (!stall_i) begin
          instr_d = instr_in;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          // A HALT word is still delivered to decode, but the PC freezes on it.
          if (instr_in == HALT_INSTR) state_d = HALT;
          else                        pc_d    = pc_q + PC_WIDTH'(1);
        end
      end
      HALT: begin
        if (redirect) begin
          state_d = RUN;
          pc_d    = redirectTarget;
          instr_d = NOP_INSTR;
          ifpc_d  = '0;
          valid_d = 1'b0;
        end else begin
          valid_d = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign pc_out      = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = valid_q;
  assign halted_o    = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed scenarios followed by random
// stall/branch/jump traffic, checked against a rule-level fetch model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, branch_taken_i, jump_i;
  logic [15:0] branch_target_i, jump_target_i;
  logic [15:0] instr_in, pc_out, if_id_instr, if_id_pc;
  logic        if_id_valid, halted_o;

  logic [15:0] mem [0:65535];
  logic [49:0] expQ [$];
  int          compared = 0;
  int          mismatched = 0;

  // Reference model state: what fetch should look like after each edge.
  logic [15:0] mPc, mInstr, mIfPc;
  logic        mValid, mHalted, mBoot;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i), .instr_in(instr_in),
    .pc_out(pc_out), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .halted_o(halted_o)
  );

  assign instr_in = mem[pc_out];

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [49:0] act, input logic [49:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got pc=%h instr=%h ifpc=%h valid=%b halted=%b, want pc=%h instr=%h ifpc=%h valid=%b halted=%b",
               name, act[49:34], act[33:18], act[17:2], act[1], act[0],
               exp[49:34], exp[33:18], exp[17:2], exp[1], exp[0]);
    end
  endtask

  task automatic modelReset();
    mBoot = 1'b1; mHalted = 1'b0; mPc = 16'h0000;
    mInstr = 16'h0000; mIfPc = 16'h0000; mValid = 1'b0;
  endtask

  task automatic modelStep(input logic st, input logic br, input logic [15:0] bt,
                           input logic jp, input logic [15:0] jt);
    logic [15:0] tgt;
    logic [15:0] word;
    tgt = br ? bt : jt;
    if (mBoot) begin
      mBoot = 1'b0;
      if (br || jp) mPc = tgt;
    end else if (br || jp) begin
      mPc = tgt; mInstr = 16'h0000; mIfPc = 16'h0000; mValid = 1'b0; mHalted = 1'b0;
    end else if (mHalted) begin
      mValid = 1'b0;
    end else if (!st) begin
      word = mem[mPc];
      mInstr = word; mIfPc = mPc; mValid = 1'b1;
      if (word == 16'hFFFF) mHalted = 1'b1;
      else                  mPc = 16'((32'(mPc) + 1) % 65536);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then record the expectation.
  task automatic applyStimulus(input logic st, input logic br, input logic [15:0] bt,
                               input logic jp, input logic [15:0] jt);
    stall_i = st; branch_taken_i = br; branch_target_i = bt;
    jump_i = jp; jump_target_i = jt;
    @(posedge clk);
    #1;
    modelStep(st, br, bt, jp, jt);
    expQ.push_back({mPc, mInstr, mIfPc, mValid, mHalted});
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
  endtask

  task automatic resetSequence();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  // Monitor: every edge the DUT presents a new fetch state, compared to the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0)
        checkOutput("edge", {pc_out, if_id_instr, if_id_pc, if_id_valid, halted_o}, expQ.pop_front());
    end
  end

  initial begin
    for (int n = 0; n < 65536; n++) mem[n] = 16'(16'h1000 + n);
    mem[12] = 16'hFFFF;
    stall_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0;
    branch_target_i = '0; jump_target_i = '0;
    rst = 1'b1;
    #3;
    checkOutput("reset", {pc_out, if_id_instr, if_id_pc, if_id_valid, halted_o}, 50'd0);
    @(negedge clk);
    resetSequence();

    // Boot edge then sequential fetch up to pc=5
    runCycles(6);
    // Stall three cycles at pc=5, then release
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 16'd0);
    runCycles(3);
    // Stall, branch and jump together at pc=8: branch wins
    applyStimulus(1'b1, 1'b1, 16'd30, 1'b1, 16'd57);
    runCycles(2);
    // Head into the HALT word at 12; stall is ignored while halted
    applyStimulus(1'b0, 1'b0, 16'd0, 1'b1, 16'd10);
    runCycles(4);
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 16'd0);
    applyStimulus(1'b0, 1'b0, 16'd0, 1'b1, 16'd158);
    runCycles(2);
    // PC wrap from 16'hFFFF
    applyStimulus(1'b0, 1'b0, 16'd0, 1'b1, 16'hFFFF);
    runCycles(3);

    // Reset asserted between edges must clear outputs without a clock edge
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", {pc_out, if_id_instr, if_id_pc, if_id_valid, halted_o}, 50'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    runCycles(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic        st, br, jp;
      logic [15:0] bt, jt;
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 9) == 0);
      jp = ($urandom_range(0, 9) == 0);
      bt = ($urandom_range(0, 3) == 0) ? 16'(32'd12 - $urandom_range(0, 3)) : 16'($urandom);
      jt = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 1)) : 16'($urandom);
      applyStimulus(st, br, bt, jp, jt);
    end

    stall_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
